// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions: stall vector encodings and pipeline-controller FSM states.
package cpu_defs;

  // Bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages (master) and the pipeline controller (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import cpu_defs::*;

  logic             stallreq_if;
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  // flush_req is a level/pulse sampled every cycle; it is acknowledged only by a later
  // one-cycle flush pulse carrying new_pc, never by a ready signal.
  logic             flush_req;
  logic [31:0]      excp_vector_i;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             timeout;
  ctrl_state_t      dbg_state;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, excp_vector_i,
    input  stall, flush, new_pc, stall_cnt, flush_cnt, timeout, dbg_state
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req, excp_vector_i,
    output stall, flush, new_pc, stall_cnt, flush_cnt, timeout, dbg_state
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception flushes
// (RUN -> FREEZE -> FLUSH) and keeps stall/flush statistics plus a stall timeout.
module pipe_ctrl
  import cpu_defs::*;
#(
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(STALL_TIMEOUT - 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next;
  logic             r_pend;
  logic [31:0]      r_pend_vec;
  logic [31:0]      r_serve_vec;
  logic [31:0]      r_new_pc;
  logic [CNT_W-1:0] r_run_len;
  logic             r_timeout;
  logic [5:0]       w_stall;
  logic             w_go;
  logic             w_run_stalled;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // A pending or fresh request can only be served once MEM is not holding the pipe.
  assign w_go = (r_state == ST_RUN) && (bus.flush_req || r_pend) && !bus.stallreq_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN:    if (w_go) w_next = ST_FREEZE;
      ST_FREEZE: w_next = ST_FLUSH;
      ST_FLUSH:  w_next = ST_RUN;
      default:   w_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_stall = STALL_NONE;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          if (bus.stallreq_mem)     w_stall = STALL_MEM;
          else if (bus.stallreq_ex) w_stall = STALL_EX;
          else if (bus.stallreq_id) w_stall = STALL_ID;
          else if (bus.stallreq_if) w_stall = STALL_IF;
          else                      w_stall = STALL_NONE;
        end
        ST_FREEZE: w_stall = STALL_ALL;
        default:   w_stall = STALL_NONE;
      endcase
    end
  end

  // The served vector moves out of the pending latch on entry to FREEZE, so a request
  // arriving during FREEZE/FLUSH can be latched as the next one without clobbering it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_vec  <= '0;
      r_serve_vec <= '0;
      r_new_pc    <= '0;
    end else begin
      if (w_go) begin
        r_serve_vec <= r_pend ? r_pend_vec : bus.excp_vector_i;
        r_pend      <= 1'b0;
      end else if (bus.flush_req && !r_pend) begin
        r_pend     <= 1'b1;
        r_pend_vec <= bus.excp_vector_i;
      end
      if (r_state == ST_FREEZE) begin
        r_new_pc <= r_serve_vec;
      end
    end
  end

  assign w_run_stalled = (r_state == ST_RUN) && w_stall[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_len <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_run_stalled) begin
        r_run_len <= '0;
      end else if (r_run_len != '1) begin
        r_run_len <= r_run_len + CNT_W'(1);
      end
      if (w_run_stalled && (r_run_len == TO_LAST)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall[0]),
    .o_count (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_state == ST_FREEZE),
    .o_count (w_flush_cnt)
  );

  assign bus.stall     = w_stall;
  assign bus.flush     = (r_state == ST_FLUSH);
  assign bus.new_pc    = r_new_pc;
  assign bus.stall_cnt = w_stall_cnt;
  assign bus.flush_cnt = w_flush_cnt;
  assign bus.timeout   = r_timeout;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, flush sequencing, timeout, counters, async reset.
module tb_pipe_ctrl;
  import cpu_defs::*;

  localparam int CNT_W = 4;
  localparam int STALL_TIMEOUT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W), .STALL_TIMEOUT(STALL_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.stallreq_if   = 1'b0;
    bus.stallreq_id   = 1'b0;
    bus.stallreq_ex   = 1'b0;
    bus.stallreq_mem  = 1'b0;
    bus.flush_req     = 1'b0;
    bus.excp_vector_i = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive_idle();
    rst = 1'b1;
    bus.stallreq_mem = 1'b1;
    #2;
    chk("rst_stall", 64'(bus.stall), 64'h0);
    chk("rst_flush", 64'(bus.flush), 64'h0);
    chk("rst_new_pc", 64'(bus.new_pc), 64'h0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'h0);
    chk("rst_flush_cnt", 64'(bus.flush_cnt), 64'h0);
    chk("rst_timeout", 64'(bus.timeout), 64'h0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_RUN));
    tick();
    rst = 1'b0;
    drive_idle();
    tick();

    // Stall priority
    bus.stallreq_id = 1'b1; bus.stallreq_mem = 1'b1;
    #1; chk("prio_mem_id", 64'(bus.stall), 64'h1F);
    tick();
    bus.stallreq_mem = 1'b0;
    #1; chk("prio_id", 64'(bus.stall), 64'h07);
    tick();
    bus.stallreq_id = 1'b0;
    #1; chk("prio_none", 64'(bus.stall), 64'h00);
    chk("prio_stall_cnt", 64'(bus.stall_cnt), 64'd2);
    bus.stallreq_if = 1'b1; bus.stallreq_id = 1'b1;
    #1; chk("prio_id_if", 64'(bus.stall), 64'h07);
    bus.stallreq_id = 1'b0;
    #1; chk("prio_if", 64'(bus.stall), 64'h03);
    bus.stallreq_if = 1'b0;
    tick();

    // Timeout: 3 stalled cycles do not trip it, 4 do
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("to3_stall", 64'(bus.stall), 64'h0F);
      tick();
    end
    bus.stallreq_ex = 1'b0;
    #1; chk("to3_timeout", 64'(bus.timeout), 64'h0);
    chk("to3_stall_cnt", 64'(bus.stall_cnt), 64'd5);
    tick();
    bus.stallreq_ex = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.stallreq_ex = 1'b0;
    #1; chk("to4_timeout", 64'(bus.timeout), 64'h1);
    chk("to4_stall_cnt", 64'(bus.stall_cnt), 64'd9);
    tick();
    chk("to4_sticky", 64'(bus.timeout), 64'h1);
    do_reset();
    #1; chk("to_cleared", 64'(bus.timeout), 64'h0);
    chk("cnt_cleared", 64'(bus.stall_cnt), 64'h0);
    tick();

    // Basic flush
    bus.flush_req = 1'b1; bus.excp_vector_i = 32'hBFC00380;
    #1; chk("bf_n_stall", 64'(bus.stall), 64'h00);
    chk("bf_n_flush", 64'(bus.flush), 64'h0);
    tick();
    bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("bf_n1_stall", 64'(bus.stall), 64'h3F);
    chk("bf_n1_flush", 64'(bus.flush), 64'h0);
    chk("bf_n1_state", 64'(bus.dbg_state), 64'(ST_FREEZE));
    tick();
    #1; chk("bf_n2_flush", 64'(bus.flush), 64'h1);
    chk("bf_n2_new_pc", 64'(bus.new_pc), 64'hBFC00380);
    chk("bf_n2_stall", 64'(bus.stall), 64'h00);
    chk("bf_n2_flush_cnt", 64'(bus.flush_cnt), 64'd1);
    chk("bf_n2_stall_cnt", 64'(bus.stall_cnt), 64'd1);
    tick();
    #1; chk("bf_n3_flush", 64'(bus.flush), 64'h0);
    chk("bf_n3_new_pc_hold", 64'(bus.new_pc), 64'hBFC00380);
    tick();

    // Deferred flush behind a MEM stall; a second request while pending is dropped
    bus.stallreq_mem = 1'b1; bus.flush_req = 1'b1; bus.excp_vector_i = 32'h80000180;
    #1; chk("df_stall0", 64'(bus.stall), 64'h1F);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.flush_req     = (i == 1);
      bus.excp_vector_i = (i == 1) ? 32'hDEADBEEF : 32'h0;
      #1; chk("df_stall", 64'(bus.stall), 64'h1F);
      chk("df_flush", 64'(bus.flush), 64'h0);
      tick();
    end
    bus.stallreq_mem = 1'b0; bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("df_release_stall", 64'(bus.stall), 64'h00);
    chk("df_timeout", 64'(bus.timeout), 64'h1);
    tick();
    #1; chk("df_freeze", 64'(bus.stall), 64'h3F);
    tick();
    #1; chk("df_flush_pulse", 64'(bus.flush), 64'h1);
    chk("df_new_pc", 64'(bus.new_pc), 64'h80000180);
    chk("df_flush_cnt", 64'(bus.flush_cnt), 64'd2);
    tick();
    tick();
    #1; chk("df_no_extra", 64'(bus.dbg_state), 64'(ST_RUN));
    tick();

    // Back-to-back flushes
    do_reset();
    bus.flush_req = 1'b1; bus.excp_vector_i = 32'h12345678;
    tick();
    bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("bb_freeze1", 64'(bus.stall), 64'h3F);
    tick();
    bus.flush_req = 1'b1; bus.excp_vector_i = 32'h00000100;
    #1; chk("bb_flush1", 64'(bus.flush), 64'h1);
    chk("bb_new_pc1", 64'(bus.new_pc), 64'h12345678);
    tick();
    bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("bb_run_state", 64'(bus.dbg_state), 64'(ST_RUN));
    chk("bb_run_stall", 64'(bus.stall), 64'h00);
    chk("bb_run_flush", 64'(bus.flush), 64'h0);
    tick();
    #1; chk("bb_freeze2", 64'(bus.stall), 64'h3F);
    tick();
    #1; chk("bb_flush2", 64'(bus.flush), 64'h1);
    chk("bb_new_pc2", 64'(bus.new_pc), 64'h00000100);
    chk("bb_flush_cnt", 64'(bus.flush_cnt), 64'd2);
    tick();

    // Async reset in the middle of FREEZE
    bus.flush_req = 1'b1; bus.excp_vector_i = 32'h11111111;
    tick();
    bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("ar_freeze", 64'(bus.stall), 64'h3F);
    rst = 1'b1;
    #1; chk("ar_stall", 64'(bus.stall), 64'h00);
    chk("ar_flush", 64'(bus.flush), 64'h0);
    chk("ar_new_pc", 64'(bus.new_pc), 64'h0);
    chk("ar_stall_cnt", 64'(bus.stall_cnt), 64'h0);
    chk("ar_flush_cnt", 64'(bus.flush_cnt), 64'h0);
    chk("ar_state", 64'(bus.dbg_state), 64'(ST_RUN));
    rst = 1'b0;
    tick();
    #1; chk("ar_idle_state", 64'(bus.dbg_state), 64'(ST_RUN));
    bus.flush_req = 1'b1; bus.excp_vector_i = 32'h22220000;
    tick();
    bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
    #1; chk("ar_re_freeze", 64'(bus.stall), 64'h3F);
    tick();
    #1; chk("ar_re_flush", 64'(bus.flush), 64'h1);
    chk("ar_re_new_pc", 64'(bus.new_pc), 64'h22220000);
    chk("ar_re_flush_cnt", 64'(bus.flush_cnt), 64'd1);
    tick();

    // Counter saturation (CNT_W=4 -> 15)
    bus.stallreq_id = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.stallreq_id = 1'b0;
    #1; chk("sat_stall_cnt", 64'(bus.stall_cnt), 64'd15);
    tick();
    for (int i = 0; i < 15; i++) begin
      bus.flush_req = 1'b1; bus.excp_vector_i = 32'(i + 32'h400);
      tick();
      bus.flush_req = 1'b0; bus.excp_vector_i = 32'h0;
      tick();
      tick();
    end
    #1; chk("sat_flush_cnt", 64'(bus.flush_cnt), 64'd15);
    chk("sat_last_new_pc", 64'(bus.new_pc), 64'h40E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
